// File: rtl/set_mode_ctrl_if.sv
// Button inputs and display/increment outputs of the alarm-clock mode controller.
// The controller itself uses the slave side; the button source uses master.
interface set_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic [1:0] S;
    logic [1:0] CW;
    logic [1:0] CW1;
    logic       BLINK;
    logic       inc_pulse;
    logic [2:0] inc_sel;

    modport master (
        output btn_mode, btn_next, btn_inc,
        input  S, CW, CW1, BLINK, inc_pulse, inc_sel
    );

    modport slave (
        input  btn_mode, btn_next, btn_inc,
        output S, CW, CW1, BLINK, inc_pulse, inc_sel
    );
endinterface

// File: rtl/set_mode_ctrl.sv
// Alarm-clock UI front end: button edge detection, mode FSM, digit cursors,
// increment strobes, blink phase and idle return to RUN.
module set_mode_ctrl #(
    parameter int BLINK_DIV    = 25000000,
    parameter int IDLE_TOGGLES = 20
) (
    input logic           clk,
    input logic           rst_n,
    set_mode_ctrl_if.slave bus
);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (IDLE_TOGGLES > 0) ? $clog2(IDLE_TOGGLES + 1) : 1;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        ALARM_VIEW = 2'b01,
        SET_TIME   = 2'b10,
        SET_ALARM  = 2'b11
    } mode_t;

    mode_t         state;
    logic [1:0]    cw;
    logic [1:0]    cw1;
    logic          blink;
    logic          inc_pulse;
    logic [2:0]    inc_sel;
    logic [BW-1:0] blink_cnt;
    logic [IW-1:0] idle_cnt;

    // bit 0 = mode, bit 1 = next, bit 2 = inc
    logic [2:0] btn;
    logic [2:0] s1, s2, s3;
    logic [2:0] press;
    logic       do_mode, do_next, do_inc, accepted, tc, timeout;

    assign btn = {bus.btn_inc, bus.btn_next, bus.btn_mode};

    always_comb begin
        press    = s2 & ~s3;
        do_mode  = press[0];
        do_next  = press[1] & ~press[0];
        do_inc   = press[2] & ~press[1] & ~press[0] & state[1];
        accepted = do_mode | do_next | do_inc;
        tc       = (blink_cnt == BW'(BLINK_DIV - 1));
        // A press in the same cycle suppresses the toggle and so the timeout.
        timeout  = !accepted && tc && (state != RUN) &&
                   (idle_cnt == IW'(IDLE_TOGGLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            state     <= RUN;
            cw        <= '0;
            cw1       <= '0;
            blink     <= 1'b1;
            inc_pulse <= 1'b0;
            inc_sel   <= '0;
            blink_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;

            inc_pulse <= do_inc;
            if (do_inc) begin
                inc_sel <= {state[0], state[0] ? cw : cw1};
            end

            if (accepted) begin
                blink_cnt <= '0;
                blink     <= 1'b1;
            end else if (tc) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (do_mode) begin
                case (state)
                    RUN: begin
                        state <= SET_TIME;
                        cw1   <= '0;
                    end
                    SET_TIME: begin
                        state <= SET_ALARM;
                        cw    <= '0;
                    end
                    SET_ALARM:  state <= RUN;
                    ALARM_VIEW: begin
                        state <= SET_ALARM;
                        cw    <= '0;
                    end
                endcase
            end else if (do_next) begin
                case (state)
                    RUN:        state <= ALARM_VIEW;
                    ALARM_VIEW: state <= RUN;
                    SET_TIME:   cw1   <= cw1 + 2'd1;
                    SET_ALARM:  cw    <= cw + 2'd1;
                endcase
            end else if (timeout) begin
                state <= RUN;
            end

            if (accepted || timeout || state == RUN) begin
                idle_cnt <= '0;
            end else if (tc) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    assign bus.S         = state;
    assign bus.CW        = cw;
    assign bus.CW1       = cw1;
    assign bus.BLINK     = blink;
    assign bus.inc_pulse = inc_pulse;
    assign bus.inc_sel   = inc_sel;
endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: vector table, hand sequences for latency, increment,
// async reset and timeout, then random presses against an event-level model.
module tb_set_mode_ctrl;
    localparam int BLINK_DIV    = 4;
    localparam int IDLE_TOGGLES = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    set_mode_ctrl_if bus();

    set_mode_ctrl #(
        .BLINK_DIV   (BLINK_DIV),
        .IDLE_TOGGLES(IDLE_TOGGLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode number 0..3, cursors indexed 0 = time, 1 = alarm.
    int         m_mode;
    int         m_cur[2];
    bit         m_blink;
    bit         m_pulse;
    int         m_sel;
    int         m_age;
    int         m_idle;
    logic [2:0] m_prev;
    logic [2:0] m_pipe[$];
    int         mode_tab[4] = '{2, 3, 3, 0};

    typedef struct {
        logic [2:0] btn;
        logic [1:0] s;
        logic [1:0] cw;
        logic [1:0] cw1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] b, logic [1:0] s, logic [1:0] cw, logic [1:0] cw1);
        vec_t v;
        v.btn = b;
        v.s   = s;
        v.cw  = cw;
        v.cw1 = cw1;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_cur[0] = 0;
        m_cur[1] = 0;
        m_blink  = 1'b1;
        m_pulse  = 1'b0;
        m_sel    = 0;
        m_age    = 0;
        m_idle   = 0;
        m_prev   = '0;
        m_pipe.delete();
    endtask

    // A rising input acts on the third clock edge that sees it high.
    task automatic model_step();
        logic [2:0] now, rise, act;
        bit acc, tog;
        now    = {bus.btn_inc, bus.btn_next, bus.btn_mode};
        rise   = now & ~m_prev;
        m_prev = now;
        m_pipe.push_back(rise);
        act = '0;
        if (m_pipe.size() > 2) act = m_pipe.pop_front();
        m_pulse = 1'b0;
        acc     = 1'b0;
        if (act[0]) begin
            m_mode = mode_tab[m_mode];
            if (m_mode == 2) m_cur[0] = 0;
            if (m_mode == 3) m_cur[1] = 0;
            acc = 1'b1;
        end else if (act[1]) begin
            if (m_mode >= 2) m_cur[m_mode-2] = (m_cur[m_mode-2] + 1) % 4;
            else m_mode = 1 - m_mode;
            acc = 1'b1;
        end else if (act[2] && m_mode >= 2) begin
            m_pulse = 1'b1;
            m_sel   = (m_mode - 2) * 4 + m_cur[m_mode-2];
            acc     = 1'b1;
        end
        if (acc) begin
            m_age   = 0;
            m_blink = 1'b1;
            m_idle  = 0;
        end else begin
            m_age++;
            tog = (m_age % BLINK_DIV) == 0;
            if (tog) m_blink = ~m_blink;
            if (m_mode == 0) m_idle = 0;
            else if (tog) begin
                m_idle++;
                if (m_idle == IDLE_TOGGLES) begin
                    m_mode = 0;
                    m_idle = 0;
                end
            end
        end
    endtask

    function automatic logic [10:0] model_vec();
        return {2'(m_mode), 2'(m_cur[1]), 2'(m_cur[0]), m_blink, m_pulse, 3'(m_sel)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.S, bus.CW, bus.CW1, bus.BLINK, bus.inc_pulse, bus.inc_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check("cycle_model", 16'(dut_vec()), 16'(model_vec()));
    endtask

    task automatic drive(logic [2:0] b);
        bus.btn_mode = b[0];
        bus.btn_next = b[1];
        bus.btn_inc  = b[2];
    endtask

    task automatic press(logic [2:0] b, int hold, int after);
        drive(b);
        repeat (hold) tick();
        drive(3'b000);
        repeat (after) tick();
    endtask

    initial begin
        int npulse;
        drive(3'b000);
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_vals", 16'(dut_vec()), 16'(11'b00_00_00_1_0_000));
        rst_n = 1'b1;

        for (int k = 1; k <= 12; k++) begin
            tick();
            check("blink_phase", 16'(bus.BLINK), 16'(((k / 4) % 2 == 0) ? 1 : 0));
        end

        vecs.push_back(mk(3'b001, 2'd2, 2'd0, 2'd0));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd1));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd2));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd3));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd0));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd1));
        vecs.push_back(mk(3'b001, 2'd3, 2'd0, 2'd1));
        vecs.push_back(mk(3'b010, 2'd3, 2'd1, 2'd1));
        vecs.push_back(mk(3'b010, 2'd3, 2'd2, 2'd1));
        vecs.push_back(mk(3'b100, 2'd3, 2'd2, 2'd1));
        vecs.push_back(mk(3'b001, 2'd0, 2'd2, 2'd1));
        vecs.push_back(mk(3'b100, 2'd0, 2'd2, 2'd1));
        vecs.push_back(mk(3'b010, 2'd1, 2'd2, 2'd1));
        vecs.push_back(mk(3'b010, 2'd0, 2'd2, 2'd1));
        vecs.push_back(mk(3'b010, 2'd1, 2'd2, 2'd1));
        vecs.push_back(mk(3'b001, 2'd3, 2'd0, 2'd1));
        vecs.push_back(mk(3'b001, 2'd0, 2'd0, 2'd1));
        vecs.push_back(mk(3'b001, 2'd2, 2'd0, 2'd0));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd1));
        vecs.push_back(mk(3'b010, 2'd2, 2'd0, 2'd2));
        vecs.push_back(mk(3'b111, 2'd3, 2'd0, 2'd2));
        vecs.push_back(mk(3'b001, 2'd0, 2'd0, 2'd2));
        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].btn, 2, 2);
            check($sformatf("vec%0d_S", i), 16'(bus.S), 16'(vecs[i].s));
            check($sformatf("vec%0d_CW", i), 16'(bus.CW), 16'(vecs[i].cw));
            check($sformatf("vec%0d_CW1", i), 16'(bus.CW1), 16'(vecs[i].cw1));
        end

        // Mode change lands on the third edge; a long hold steps only once.
        drive(3'b001);
        tick();
        check("lat_edge1", 16'(bus.S), 16'd0);
        tick();
        check("lat_edge2", 16'(bus.S), 16'd0);
        tick();
        check("lat_edge3", 16'(bus.S), 16'd2);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("hold_single", 16'(bus.S), 16'd2);
        end
        press(3'b000, 0, 2);
        press(3'b001, 2, 2);
        check("mode_to_alarm", 16'(bus.S), 16'd3);
        press(3'b001, 2, 2);
        check("mode_to_run", 16'(bus.S), 16'd0);

        press(3'b001, 2, 2);
        press(3'b001, 2, 2);
        press(3'b010, 2, 2);
        press(3'b010, 2, 2);
        check("inc_setup_cw", 16'(bus.CW), 16'd2);
        drive(3'b100);
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) drive(3'b000);
            tick();
            if (bus.inc_pulse) begin
                npulse++;
                check("inc_sel", 16'(bus.inc_sel), 16'b110);
                check("inc_blink", 16'(bus.BLINK), 16'd1);
            end
        end
        check("inc_pulse_count", 16'(npulse), 16'd1);

        // Async reset from a non-reset state, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1 check("async_reset", 16'(dut_vec()), 16'(11'b00_00_00_1_0_000));
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        drive(3'b100);
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive(3'b000);
            tick();
            if (bus.inc_pulse) npulse++;
        end
        check("run_inc_ignored", 16'(npulse), 16'd0);

        // Plain timeout from ALARM_VIEW: three toggles after the press edge.
        press(3'b010, 2, 1);
        check("view_entered", 16'(bus.S), 16'd1);
        repeat (11) tick();
        check("view_before_to", 16'(bus.S), 16'd1);
        tick();
        check("view_timeout", 16'(bus.S), 16'd0);

        // A press landing on the third toggle wins and restarts the idle count.
        press(3'b001, 2, 2);
        press(3'b001, 2, 1);
        check("coll_setup", 16'(bus.S), 16'd3);
        repeat (9) tick();
        drive(3'b010);
        repeat (3) tick();
        check("coll_S", 16'(bus.S), 16'd3);
        check("coll_CW", 16'(bus.CW), 16'd1);
        check("coll_BLINK", 16'(bus.BLINK), 16'd1);
        drive(3'b000);
        repeat (11) tick();
        check("coll_restart", 16'(bus.S), 16'd3);
        tick();
        check("coll_timeout", 16'(bus.S), 16'd0);

        for (int it = 0; it < 300; it++) begin
            press(3'($urandom_range(1, 7)), $urandom_range(1, 6), $urandom_range(0, 14));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
